univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the next generation of the 4-bit shift register, generalised to WIDTH bits. It adds a counted burst mode that autonomously performs CNT shift or rotate steps with BUSY/DONE status. It sits between the control sequencer and the serial link, and serves both as a single-step register and as a self-timed serialiser.

## Interface
- WIDTH, 4, register width in bits (≥2)
- CNT_W, 4, width of burst count; max burst = 2^CNT_W − 1
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- ENB  input  1  step enable; in burst mode, pauses the burst when 0
- DIR  input  1  0 = left (toward MSB), 1 = right (toward LSB)
- S_IN  input  1  serial input bit; enters the vacated end on a serial shift
- MODO  input  2  00 serial shift, 01 circular rotate, 10 parallel load, 11 hold
- D  input  WIDTH  parallel load data
- START  input  1  request burst (sampled only when idle)
- CNT  input  CNT_W  number of burst steps
- Q  output  WIDTH  register contents
- S_OUT  output  1  bit leaving the register: Q[WIDTH-1] if DIR=0, Q[0] if DIR=1 (live DIR, or latched dir while BUSY)
- BUSY  output  1  burst in progress
- DONE  output  1  one-cycle pulse at burst completion

One clock, CLK; reset RST is synchronous and active-high.

## Operation
- Reset (highest priority): Q=0, BUSY=0, DONE=0, internal count=0, latched mode/dir=0. Reset mid-burst aborts the burst with no DONE pulse.
- Step mode (BUSY=0, no burst start), each edge with ENB=1:
  - 00 left: Q ← {Q[WIDTH-2:0], S_IN}; right: Q ← {S_IN, Q[WIDTH-1:1]}
  - 01 left: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}; right: Q ← {Q[0], Q[WIDTH-1:1]}
  - 10: Q ← D (DIR ignored)
  - 11: Q held
  - ENB=0: Q held regardless of MODO.
- Burst start: when idle, START=1 and MODO ∈ {00,01}, independent of ENB. That edge latches MODO[0] and DIR, loads count ← CNT, and performs no shift.
  - CNT≠0: BUSY←1.
  - CNT=0: BUSY stays 0 and DONE←1 for one cycle; Q unchanged.
- START=1 with MODO ∈ {10,11}: treated as a normal step-mode cycle; no burst.
- Burst mode (BUSY=1): MODO, DIR, D, CNT and START are ignored. S_IN stays live and is sampled on each serial step.
  - Edge with ENB=1: one step of the latched operation/direction; count decrements.
  - Edge with ENB=0: pause; Q and count held.
  - Edge performing the step with count=1: BUSY←0 and DONE←1.
- DONE is high for exactly one cycle, then cleared on the next edge unless another CNT=0 start occurs.
- A START asserted in the same cycle DONE is high is accepted, because BUSY is already 0.
- Counter: CNT_W bits, no wrap. It is loaded only at burst start and never decremented below 0.

## Timing
- Step-mode Q update: visible one cycle after the sampling edge (registered).
- Burst latency: START at edge k → BUSY=1 after edge k.
  - With ENB held 1, shifts occur at edges k+1 … k+CNT.
  - BUSY=0 and DONE=1 after edge k+CNT.
  - Total: CNT+1 cycles from START to DONE.
- Each ENB=0 cycle during a burst adds one cycle of latency.
- S_OUT is combinational from Q and the effective direction; no added latency.
- BUSY and DONE are registered; no combinational path from inputs.

## Test plan
- WIDTH=4: load D=0001 (MODO=10, ENB=1), then 4 rotate-left steps (MODO=01, DIR=0) → Q = 0010, 0100, 1000, 0001; S_OUT = 0,0,1,0 after each edge.
- Burst rotate left: Q=0001, START=1, CNT=5, ENB=1 → BUSY high 5 cycles, Q=0010 at end, DONE pulses once, 6 cycles after START.
- Burst serial right: Q=1111, S_IN=0, DIR=1, CNT=3 → Q = 0111, 0011, 0001; DONE after third step. Toggling MODO/DIR mid-burst has no effect.
- ENB pause: burst CNT=4 with ENB=0 for 2 cycles mid-burst → exactly 4 shifts; DONE delayed by 2 cycles; Q held during the pause.
- CNT=0 start → no BUSY, DONE=1 for one cycle after the start edge, Q unchanged. START with MODO=10 → plain load, BUSY stays 0.
- RST=1 during the second burst step → next cycle Q=0000, BUSY=0, DONE never pulses. A new START afterwards runs normally.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Bundle of control, data and status signals for univ_shift_reg.
//   master  : the control sequencer side (drives ENB/DIR/S_IN/MODO/D/START/CNT,
//             observes Q/S_OUT/BUSY/DONE)
//   slave   : the shift register itself
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             ENB;    // step enable / burst pause when low
  logic             DIR;    // 0 = toward MSB, 1 = toward LSB
  logic             S_IN;   // serial input bit
  logic [1:0]       MODO;   // 00 shift, 01 rotate, 10 load, 11 hold
  logic [WIDTH-1:0] D;      // parallel load data
  logic             START;  // burst request
  logic [CNT_W-1:0] CNT;    // burst step count
  logic [WIDTH-1:0] Q;      // register contents
  logic             S_OUT;  // bit leaving the register
  logic             BUSY;   // burst in progress
  logic             DONE;   // one-cycle burst completion pulse

  modport master (
    output ENB, DIR, S_IN, MODO, D, START, CNT,
    input  Q, S_OUT, BUSY, DONE
  );

  modport slave (
    input  ENB, DIR, S_IN, MODO, D, START, CNT,
    output Q, S_OUT, BUSY, DONE
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with a counted burst mode.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous, active-high reset
//   bus  : univ_shift_reg_if.slave -- step controls (ENB, DIR, S_IN, MODO, D),
//          burst controls (START, CNT) and outputs (Q, S_OUT, BUSY, DONE)
// Step mode applies one shift/rotate/load/hold per enabled edge. A START with
// MODO in {00,01} latches the operation and direction and then performs CNT
// steps on its own, one per ENB=1 edge, raising DONE for one cycle at the end.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt_r;
  logic             busy;
  logic             done;
  logic             rot_r;   // latched MODO[0]: 0 serial shift, 1 rotate
  logic             dir_r;   // latched DIR for the burst
  logic             eff_dir;

  // One shift or rotate step; the entering bit is S_IN for a shift or the
  // bit falling off the opposite end for a rotate.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [WIDTH-1:0] v,
    input logic             rot,
    input logic             dir,
    input logic             sin
  );
    logic in_bit;
    in_bit = rot ? (dir ? v[0] : v[WIDTH-1]) : sin;
    return dir ? {in_bit, v[WIDTH-1:1]} : {v[WIDTH-2:0], in_bit};
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      q     <= '0;
      cnt_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rot_r <= 1'b0;
      dir_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        // Burst: only ENB and S_IN are live; everything else was latched.
        if (bus.ENB && cnt_r != '0) begin
          q     <= step_op(q, rot_r, dir_r, bus.S_IN);
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end else if (bus.START && !bus.MODO[1]) begin
        // Burst start edge: latch only, no shift. CNT=0 completes at once.
        rot_r <= bus.MODO[0];
        dir_r <= bus.DIR;
        cnt_r <= bus.CNT;
        if (bus.CNT != '0) busy <= 1'b1;
        else               done <= 1'b1;
      end else if (bus.ENB) begin
        case (bus.MODO)
          2'b00:   q <= step_op(q, 1'b0, bus.DIR, bus.S_IN);
          2'b01:   q <= step_op(q, 1'b1, bus.DIR, bus.S_IN);
          2'b10:   q <= bus.D;
          default: q <= q;
        endcase
      end
    end
  end

  // While a burst runs the outgoing end follows the latched direction.
  assign eff_dir   = busy ? dir_r : bus.DIR;
  assign bus.S_OUT = eff_dir ? q[0] : q[WIDTH-1];
  assign bus.Q     = q;
  assign bus.BUSY  = busy;
  assign bus.DONE  = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic             rst, enb, dir, sin;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] eq;
    logic             es, eb, ed;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             sout, busy, done;
    int               tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, enb, dir, sin, input logic [1:0] modo,
                              input logic [WIDTH-1:0] d, input logic start,
                              input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] eq,
                              input logic es, eb, ed);
    vec_t v;
    v.rst = rst; v.enb = enb; v.dir = dir; v.sin = sin; v.modo = modo; v.d = d;
    v.start = start; v.cnt = cnt; v.eq = eq; v.es = es; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic drive(input logic rst, enb, dir, sin, input logic [1:0] modo,
                       input logic [WIDTH-1:0] d, input logic start, input logic [CNT_W-1:0] cnt);
    RST = rst; bus.ENB = enb; bus.DIR = dir; bus.S_IN = sin; bus.MODO = modo;
    bus.D = d; bus.START = start; bus.CNT = cnt;
  endtask

  task automatic chk1(input string nm, input int tag, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b want %b", nm, tag, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard empty: got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    chk1("q",    e.tag, bus.Q, e.q);
    chk1("sout", e.tag, WIDTH'(bus.S_OUT), WIDTH'(e.sout));
    chk1("busy", e.tag, WIDTH'(bus.BUSY),  WIDTH'(e.busy));
    chk1("done", e.tag, WIDTH'(bus.DONE),  WIDTH'(e.done));
  endtask

  // Independent behavioural model for the random phase.
  logic [WIDTH-1:0] m_q;
  logic [CNT_W-1:0] m_cnt;
  logic             m_busy, m_done, m_rot, m_dir;

  function automatic logic [WIDTH-1:0] m_step(input logic [WIDTH-1:0] v, input logic rot,
                                               input logic dir, input logic sin);
    logic [WIDTH-1:0] n;
    for (int i = 0; i < WIDTH; i++) begin
      if (!dir) n[i] = (i == 0) ? (rot ? v[WIDTH-1] : sin) : v[i-1];
      else      n[i] = (i == WIDTH-1) ? (rot ? v[0] : sin) : v[i+1];
    end
    return n;
  endfunction

  task automatic m_clock(input logic rst, enb, dir, sin, input logic [1:0] modo,
                         input logic [WIDTH-1:0] d, input logic start, input logic [CNT_W-1:0] cnt);
    logic nd;
    nd = 1'b0;
    if (rst) begin
      m_q = '0; m_cnt = '0; m_busy = 0; m_rot = 0; m_dir = 0;
    end else if (m_busy) begin
      if (enb) begin
        m_q = m_step(m_q, m_rot, m_dir, sin);
        if (m_cnt == 1) begin m_busy = 0; nd = 1'b1; end
        m_cnt = m_cnt - 1;
      end
    end else if (start && (modo == 2'b00 || modo == 2'b01)) begin
      m_rot = modo[0]; m_dir = dir; m_cnt = cnt;
      if (cnt == 0) nd = 1'b1; else m_busy = 1'b1;
    end else if (enb) begin
      if (modo == 2'b10) m_q = d;
      else if (modo != 2'b11) m_q = m_step(m_q, modo[0], dir, sin);
    end
    m_done = nd;
  endtask

  initial begin
    exp_t e;
    int   tag;
    drive(1, 0, 0, 0, 2'b11, '0, 0, '0);

    //        rst enb dir sin modo   d      st cnt  | q     so bsy dn
    // reset, load 0001, four rotate-left steps
    tbl.push_back(mk(1, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 4'b0001, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 0, 0, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 0, 0, 4'b0100, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 0, 0, 4'b1000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 0, 0, 4'b0001, 0, 0, 0));
    // burst rotate left CNT=5, MODO toggled to hold while busy
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 1, 5, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 4'b1111, 1, 9, 4'b0100, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 0, 0));
    // burst serial right CNT=3 from 1111; live DIR/MODO/D toggled, latched dir drives S_OUT
    tbl.push_back(mk(0, 1, 1, 0, 2'b10, 4'b1111, 0, 0, 4'b1111, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b00, 4'b0000, 1, 3, 4'b1111, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 0, 0, 4'b0111, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 4'b1010, 0, 0, 4'b0011, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b11, 4'b0000, 0, 0, 4'b0001, 1, 0, 1));
    // burst rotate left CNT=4 with a two-cycle ENB pause
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 1, 4, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0100, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0001, 0, 0, 1));
    // CNT=0 starts back to back, then START with load / hold modes
    tbl.push_back(mk(0, 1, 0, 1, 2'b00, 4'b0000, 1, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b01, 4'b0000, 1, 0, 4'b0001, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 4'b0110, 1, 5, 4'b0110, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b1111, 1, 5, 4'b0110, 0, 0, 0));
    // reset during the second burst step, then a fresh burst rotate right
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 4'b0000, 1, 3, 4'b0110, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b1100, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b10, 4'b0001, 0, 0, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b01, 4'b0000, 1, 2, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 4'b0000, 0, 0, 4'b1000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b11, 4'b0000, 0, 0, 4'b0100, 0, 0, 1));
    // START accepted in the DONE cycle: serial left CNT=1 shifting in a 1
    tbl.push_back(mk(0, 1, 0, 1, 2'b00, 4'b0000, 1, 1, 4'b0100, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 2'b11, 4'b0000, 0, 0, 4'b1001, 1, 0, 1));
    // step-mode serial shifts and ENB=0 hold
    tbl.push_back(mk(0, 1, 0, 1, 2'b00, 4'b0000, 0, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 4'b1001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b10, 4'b1111, 0, 0, 4'b1001, 1, 0, 0));

    @(negedge CLK);
    tag = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].enb, tbl[i].dir, tbl[i].sin, tbl[i].modo,
            tbl[i].d, tbl[i].start, tbl[i].cnt);
      e.q = tbl[i].eq; e.sout = tbl[i].es; e.busy = tbl[i].eb; e.done = tbl[i].ed; e.tag = tag++;
      sb.push_back(e);
      @(posedge CLK); #1;
      compare_out();
      @(negedge CLK);
    end

    // Random phase against the behavioural model, starting from reset.
    for (int n = 0; n < 400; n++) begin
      logic rst, enb, dir, sin, st;
      logic [1:0] modo;
      logic [WIDTH-1:0] d;
      logic [CNT_W-1:0] cnt;
      rst  = (n == 0) || ($urandom_range(0, 49) == 0);
      enb  = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom);
      sin  = 1'($urandom);
      modo = 2'($urandom);
      d    = WIDTH'($urandom);
      st   = ($urandom_range(0, 3) == 0);
      cnt  = CNT_W'($urandom_range(0, 6));
      drive(rst, enb, dir, sin, modo, d, st, cnt);
      m_clock(rst, enb, dir, sin, modo, d, st, cnt);
      e.q = m_q; e.busy = m_busy; e.done = m_done; e.tag = tag++;
      e.sout = (m_busy ? m_dir : dir) ? m_q[0] : m_q[WIDTH-1];
      sb.push_back(e);
      @(posedge CLK); #1;
      compare_out();
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
